// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit with private HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus a sign-fix cycle.
module ex_muldiv_unit #(
  parameter int DATA_BUS_WIDTH     = 32,
  parameter int ALU_CTRL_BUS_WIDTH = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_flush,
  input  logic [ALU_CTRL_BUS_WIDTH-1:0] i_alu_ctrl,
  input  logic [DATA_BUS_WIDTH-1:0]     i_data_a,
  input  logic [DATA_BUS_WIDTH-1:0]     i_data_b,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [DATA_BUS_WIDTH-1:0]     o_hi,
  output logic [DATA_BUS_WIDTH-1:0]     o_lo
);

  localparam int W = DATA_BUS_WIDTH;
  localparam logic [4:0] LAST_ITER = 5'(W - 1);

  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_MULT  = 6'b011000;
  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_MULTU = 6'b011001;
  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_DIV   = 6'b011010;
  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_DIVU  = 6'b011011;
  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_MTHI  = 6'b010001;
  localparam logic [ALU_CTRL_BUS_WIDTH-1:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [4:0]       cnt_r;
  logic [2*W-1:0]   prod_r;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     opnd_r;     // mult: |multiplicand|; div: |divisor|
  logic [W-1:0]     a_r;
  logic             div_r;
  logic             res_neg_r;
  logic             rem_neg_r;
  logic [W-1:0]     hi_r, lo_r;
  logic             busy_r, done_r;

  logic             is_mul_s, is_div_s, is_signed_s, is_mthi_s, is_mtlo_s;
  logic             sa_s, sb_s;
  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_next_s;
  logic [W:0]       div_shift_s, div_diff_s;
  logic [2*W-1:0]   div_next_s;
  logic [2*W-1:0]   prod_fix_s;
  logic [W-1:0]     fix_hi_s, fix_lo_s;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? ({W{1'b0}} - v) : v;
  endfunction

  // Decode the funct-coded control bus
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    is_mthi_s   = 1'b0;
    is_mtlo_s   = 1'b0;
    case (i_alu_ctrl)
      OP_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
      OP_MULTU: is_mul_s = 1'b1;
      OP_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
      OP_DIVU:  is_div_s = 1'b1;
      OP_MTHI:  is_mthi_s = 1'b1;
      OP_MTLO:  is_mtlo_s = 1'b1;
      default:  is_mul_s = 1'b0;
    endcase
    sa_s = is_signed_s & i_data_a[W-1];
    sb_s = is_signed_s & i_data_b[W-1];
  end

  // One iteration step of each algorithm and the final sign correction
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    mul_next_s  = {mul_sum_s, prod_r[W-1:1]};
    div_shift_s = {prod_r[2*W-1:W], prod_r[W-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (div_diff_s[W]) begin
      div_next_s = {div_shift_s[W-1:0], prod_r[W-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[W-1:0], prod_r[W-2:0], 1'b1};
    end
    prod_fix_s = res_neg_r ? ({(2*W){1'b0}} - prod_r) : prod_r;
    if (!div_r) begin
      fix_hi_s = prod_fix_s[2*W-1:W];
      fix_lo_s = prod_fix_s[W-1:0];
    end else if (opnd_r == {W{1'b0}}) begin
      fix_hi_s = a_r;
      fix_lo_s = {W{1'b1}};
    end else begin
      fix_hi_s = cond_neg(prod_r[2*W-1:W], rem_neg_r);
      fix_lo_s = cond_neg(prod_r[W-1:0], res_neg_r);
    end
  end

  // Next-state logic; flush outranks start and aborts RUN/FIX
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!i_flush && i_start && (is_mul_s || is_div_s)) state_next_s = RUN;
        else                                                 state_next_s = IDLE;
      end
      RUN: begin
        if (i_flush)                  state_next_s = IDLE;
        else if (cnt_r == LAST_ITER)  state_next_s = FIX;
        else                          state_next_s = RUN;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and HI/LO registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      prod_r    <= {(2*W){1'b0}};
      opnd_r    <= {W{1'b0}};
      a_r       <= {W{1'b0}};
      div_r     <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      hi_r      <= {W{1'b0}};
      lo_r      <= {W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN) || (state_next_s == FIX);
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!i_flush && i_start && (is_mul_s || is_div_s)) begin
            cnt_r     <= 5'd0;
            a_r       <= i_data_a;
            div_r     <= is_div_s;
            res_neg_r <= sa_s ^ sb_s;
            rem_neg_r <= sa_s;
            if (is_div_s) begin
              opnd_r <= cond_neg(i_data_b, sb_s);
              prod_r <= {{W{1'b0}}, cond_neg(i_data_a, sa_s)};
            end else begin
              opnd_r <= cond_neg(i_data_a, sa_s);
              prod_r <= {{W{1'b0}}, cond_neg(i_data_b, sb_s)};
            end
          end else if (!i_flush && i_start && is_mthi_s) begin
            hi_r <= i_data_a;
          end else if (!i_flush && i_start && is_mtlo_s) begin
            lo_r <= i_data_a;
          end else begin
            cnt_r <= 5'd0;
          end
        end
        RUN: begin
          if (!i_flush) begin
            prod_r <= div_r ? div_next_s : mul_next_s;
            cnt_r  <= cnt_r + 5'd1;
          end else begin
            cnt_r <= 5'd0;
          end
        end
        FIX: begin
          if (!i_flush) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: cnt_r <= 5'd0;
      endcase
    end
  end

  assign o_busy = busy_r;
  assign o_done = done_r;
  assign o_hi   = hi_r;
  assign o_lo   = lo_r;

endmodule
